cpu_intr_ctrl: RTL and testbench

//  Platform interrupt controller feeding the CPU CSR file's external-interrupt input.

---
 rtl/cpu_intr_pkg.sv | 21 ++
 rtl/cpu_intr_gateway.sv | 48 ++++
 rtl/cpu_intr_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_intr_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_intr_pkg.sv
// Shared constants for the platform interrupt controller: default sizing and
// the register window layout.
package cpu_intr_pkg;

    localparam int DEF_SOURCES   = 8;
    localparam int DEF_PRIO_BITS = 3;
    localparam int ID_W          = $clog2(DEF_SOURCES + 1);
    localparam int PRIO_W        = DEF_PRIO_BITS;

    localparam logic [7:0] ADDR_PENDING   = 8'h80;
    localparam logic [7:0] ADDR_ENABLE    = 8'h84;
    localparam logic [7:0] ADDR_THRESHOLD = 8'h88;
    localparam logic [7:0] ADDR_CLAIM     = 8'h8C;

    // Register decode works on word indices; byte lanes are ignored.
    localparam logic [5:0] WORD_PENDING   = ADDR_PENDING[7:2];
    localparam logic [5:0] WORD_ENABLE    = ADDR_ENABLE[7:2];
    localparam logic [5:0] WORD_THRESHOLD = ADDR_THRESHOLD[7:2];
    localparam logic [5:0] WORD_CLAIM     = ADDR_CLAIM[7:2];

endpackage

// File: rtl/cpu_intr_gateway.sv
// Per-source gateway: turns a level line into a pending flag and tracks
// whether software is currently servicing this source.
module cpu_intr_gateway (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o,
    output logic in_service_o
);

    logic pending_q;
    logic pending_d;
    logic in_service_q;
    logic in_service_d;

    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        // A claim takes precedence over a line that is still asserted.
        if (claim_i) begin
            pending_d    = 1'b0;
            in_service_d = 1'b1;
        end else begin
            if (irq_i && !pending_q && !in_service_q) begin
                pending_d = 1'b1;
            end
            if (complete_i && in_service_q) begin
                in_service_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule

// File: rtl/cpu_intr_ctrl.sv
// Platform interrupt controller: gates, prioritises and thresholds device
// lines, exposes claim/complete registers and pulses the CSR external tick.
module cpu_intr_ctrl
    import cpu_intr_pkg::*;
#(
    parameter int SOURCES   = DEF_SOURCES,
    parameter int PRIO_BITS = DEF_PRIO_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SOURCES-1:0] src_irq,
    input  logic               sel,
    input  logic               wr,
    input  logic [7:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               ack,
    output logic               irq,
    output logic               ext_intr_tick
);

    localparam int IDW = $clog2(SOURCES + 1);

    logic [PRIO_BITS-1:0] prio_q [1:SOURCES];
    logic [PRIO_BITS-1:0] prio_d [1:SOURCES];
    logic [SOURCES:1]     enable_q;
    logic [SOURCES:1]     enable_d;
    logic [PRIO_BITS-1:0] threshold_q;
    logic [PRIO_BITS-1:0] threshold_d;
    logic [IDW-1:0]       best_id_q;
    logic [IDW-1:0]       best_id_d;
    logic [PRIO_BITS-1:0] best_prio_d;
    logic                 irq_q;
    logic                 ack_q;
    logic [31:0]          data_out_q;
    logic [31:0]          data_out_d;
    logic [31:0]          rd_data;

    logic [SOURCES:1]     pending;
    logic [SOURCES:1]     in_service;
    logic [SOURCES:1]     claim;
    logic [SOURCES:1]     complete;
    logic [SOURCES:1]     eligible;

    logic [5:0]           word;
    logic                 rd_en;
    logic                 wr_en;
    logic                 claim_hit;
    logic                 complete_hit;
    logic                 unused_addr;

    assign word         = addr[7:2];
    assign unused_addr  = ^addr[1:0];
    assign rd_en        = sel & ~wr;
    assign wr_en        = sel & wr;
    assign claim_hit    = rd_en && (word == WORD_CLAIM) && (best_id_q != '0);
    assign complete_hit = wr_en && (word == WORD_CLAIM);

    for (genvar gi = 1; gi <= SOURCES; gi++) begin : g_src
        assign claim[gi]    = claim_hit && (best_id_q == IDW'(gi));
        // Full-width compare so out-of-range IDs never alias onto a source.
        assign complete[gi] = complete_hit && (data_in == 32'(gi));
        assign eligible[gi] = pending[gi] & enable_q[gi] & (prio_q[gi] > threshold_q);

        cpu_intr_gateway u_gateway (
            .clk          (clk),
            .rst          (rst),
            .irq_i        (src_irq[gi-1]),
            .claim_i      (claim[gi]),
            .complete_i   (complete[gi]),
            .pending_o    (pending[gi]),
            .in_service_o (in_service[gi])
        );
    end

    // Scanning from the top ID with >= lets the lowest ID win a tie.
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int k = SOURCES; k >= 1; k--) begin
            if (eligible[k] && (prio_q[k] >= best_prio_d)) begin
                best_id_d   = IDW'(k);
                best_prio_d = prio_q[k];
            end
        end
    end

    always_comb begin
        prio_d      = prio_q;
        enable_d    = enable_q;
        threshold_d = threshold_q;
        if (wr_en) begin
            for (int k = 1; k <= SOURCES; k++) begin
                if (word == 6'(k)) begin
                    prio_d[k] = data_in[PRIO_BITS-1:0];
                end
            end
            if (word == WORD_ENABLE) begin
                enable_d = data_in[SOURCES:1];
            end
            if (word == WORD_THRESHOLD) begin
                threshold_d = data_in[PRIO_BITS-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 1; k <= SOURCES; k++) begin
            if (word == 6'(k)) begin
                rd_data = 32'(prio_q[k]);
            end
        end
        case (word)
            WORD_PENDING:   rd_data = 32'({pending, 1'b0});
            WORD_ENABLE:    rd_data = 32'({enable_q, 1'b0});
            WORD_THRESHOLD: rd_data = 32'(threshold_q);
            WORD_CLAIM:     rd_data = 32'(best_id_q);
            default:        ;
        endcase
        data_out_d = rd_en ? rd_data : data_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= SOURCES; k++) begin
                prio_q[k] <= '0;
            end
            enable_q    <= '0;
            threshold_q <= '0;
            best_id_q   <= '0;
            irq_q       <= 1'b0;
            ack_q       <= 1'b0;
            data_out_q  <= '0;
        end else begin
            prio_q      <= prio_d;
            enable_q    <= enable_d;
            threshold_q <= threshold_d;
            best_id_q   <= best_id_d;
            irq_q       <= irq;
            ack_q       <= sel;
            data_out_q  <= data_out_d;
        end
    end

    assign irq           = (best_id_q != '0);
    assign ext_intr_tick = irq & ~irq_q;
    assign ack           = ack_q;
    assign data_out      = data_out_q;

endmodule

// File: tb/tb_cpu_intr_ctrl.sv
// Directed bench for cpu_intr_ctrl: gateway, arbitration, threshold,
// claim/complete and reset behaviour with hand-computed expectations.
module tb_cpu_intr_ctrl;

    localparam int SOURCES   = 8;
    localparam int PRIO_BITS = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [SOURCES-1:0] src_irq;
    logic               sel;
    logic               wr;
    logic [7:0]         addr;
    logic [31:0]        data_in;
    logic [31:0]        data_out;
    logic               ack;
    logic               irq;
    logic               ext_intr_tick;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_intr_ctrl #(
        .SOURCES   (SOURCES),
        .PRIO_BITS (PRIO_BITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_irq       (src_irq),
        .sel           (sel),
        .wr            (wr),
        .addr          (addr),
        .data_in       (data_in),
        .data_out      (data_out),
        .ack           (ack),
        .irq           (irq),
        .ext_intr_tick (ext_intr_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; the access is sampled at the next rising edge.
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        sel     = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
        sel     = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        chk("ack", 32'(ack), 32'd1);
        rd = data_out;
        $display("bus %s addr=0x%02h wdata=0x%08h rdata=0x%08h irq=%0b",
                 w ? "WR" : "RD", a, d, rd, irq);
    endtask

    task automatic wreg(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic rreg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, a, 32'd0, r);
        chk(tag, r, exp);
    endtask

    task automatic pulse_src(input logic [SOURCES-1:0] v);
        src_irq = v;
        step(1);
        src_irq = '0;
        step(1);
    endtask

    initial begin
        rst     = 1'b1;
        src_irq = '0;
        sel     = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_irq",  32'(irq), 32'd0);
        chk("rst_tick", 32'(ext_intr_tick), 32'd0);
        chk("rst_ack",  32'(ack), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        rreg("rst_enable", 8'h84, 32'd0);

        // 1: single source, two-edge latency, single tick
        wreg(8'h0C, 32'd2);
        wreg(8'h84, 32'h08);
        src_irq = 8'h04;
        step(1);
        chk("t1_irq_edge1", 32'(irq), 32'd0);
        src_irq = '0;
        step(1);
        chk("t1_irq_edge2", 32'(irq), 32'd1);
        chk("t1_tick", 32'(ext_intr_tick), 32'd1);
        step(1);
        chk("t1_tick_once", 32'(ext_intr_tick), 32'd0);
        chk("t1_irq_level", 32'(irq), 32'd1);
        rreg("t1_claim", 8'h8C, 32'd3);
        rreg("t1_pending", 8'h80, 32'd0);
        wreg(8'h8C, 32'd3);
        step(1);
        chk("t1_irq_done", 32'(irq), 32'd0);

        // 2: tie on priority goes to the lower ID
        wreg(8'h08, 32'd4);
        wreg(8'h14, 32'd4);
        wreg(8'h84, 32'h24);
        pulse_src(8'h12);
        chk("t2_irq", 32'(irq), 32'd1);
        chk("t2_tick", 32'(ext_intr_tick), 32'd1);
        rreg("t2_pending", 8'h80, 32'h24);
        rreg("t2_claim_a", 8'h8C, 32'd2);
        wreg(8'h8C, 32'd2);
        rreg("t2_claim_b", 8'h8C, 32'd5);
        chk("t2_no_retick", 32'(ext_intr_tick), 32'd0);
        wreg(8'h8C, 32'd5);
        step(2);
        chk("t2_irq_done", 32'(irq), 32'd0);

        // 3: threshold masks equal priority; lowering it releases irq one edge later
        wreg(8'h88, 32'd4);
        wreg(8'h04, 32'd4);
        wreg(8'h84, 32'h02);
        src_irq = 8'h01;
        step(3);
        chk("t3_masked", 32'(irq), 32'd0);
        rreg("t3_pending_ungated", 8'h80, 32'h02);
        wreg(8'h88, 32'd3);
        chk("t3_irq_write_edge", 32'(irq), 32'd0);
        step(1);
        chk("t3_irq_next_edge", 32'(irq), 32'd1);
        chk("t3_tick", 32'(ext_intr_tick), 32'd1);

        // 4: held line re-pends one cycle after complete and ticks again
        rreg("t4_claim", 8'h8C, 32'd1);
        wreg(8'h8C, 32'd1);
        chk("t4_irq_low", 32'(irq), 32'd0);
        rreg("t4_pending_at_edge", 8'h80, 32'd0);
        rreg("t4_pending_after", 8'h80, 32'h02);
        chk("t4_irq_again", 32'(irq), 32'd1);
        chk("t4_second_tick", 32'(ext_intr_tick), 32'd1);
        src_irq = '0;
        rreg("t4_claim_again", 8'h8C, 32'd1);
        wreg(8'h8C, 32'd1);

        // 5: bogus completes are ignored; register window boundaries
        pulse_src(8'h01);
        rreg("t5_claim", 8'h8C, 32'd1);
        wreg(8'h8C, 32'd0);
        wreg(8'h8C, 32'd7);
        wreg(8'h8C, 32'd9);
        wreg(8'h8C, 32'd31);
        pulse_src(8'h01);
        rreg("t5_still_in_service", 8'h80, 32'd0);
        chk("t5_irq", 32'(irq), 32'd0);
        wreg(8'h8C, 32'd1);
        pulse_src(8'h01);
        rreg("t5_repend", 8'h80, 32'h02);
        rreg("t5_unmapped", 8'h90, 32'd0);
        rreg("t5_prio0", 8'h00, 32'd0);
        rreg("t5_prio3", 8'h0C, 32'd2);
        rreg("t5_enable", 8'h84, 32'h02);
        rreg("t5_threshold", 8'h88, 32'd3);
        wreg(8'h20, 32'hFF);
        rreg("t5_prio8_mask", 8'h20, 32'd7);
        wreg(8'h24, 32'd5);
        rreg("t5_prio9_unmapped", 8'h24, 32'd0);

        // 6: reset during a claim access drops it and clears all state
        chk("t6_irq_before", 32'(irq), 32'd1);
        sel  = 1'b1;
        wr   = 1'b0;
        addr = 8'h8C;
        #2 rst = 1'b1;
        @(negedge clk);
        sel  = 1'b0;
        addr = '0;
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_dout", data_out, 32'd0);
        chk("t6_irq", 32'(irq), 32'd0);
        chk("t6_tick", 32'(ext_intr_tick), 32'd0);
        rst = 1'b0;
        step(1);
        rreg("t6_enable", 8'h84, 32'd0);
        rreg("t6_threshold", 8'h88, 32'd0);
        rreg("t6_prio1", 8'h04, 32'd0);
        rreg("t6_pending", 8'h80, 32'd0);
        wreg(8'h04, 32'd1);
        wreg(8'h84, 32'h02);
        pulse_src(8'h01);
        rreg("t6_in_service_cleared", 8'h80, 32'h02);
        chk("t6_irq_after", 32'(irq), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
